// File: rtl/alu_res_pkg.sv
// alu_res_pkg: shift-operation and result-FIFO state encodings for the ALU result stage
package alu_res_pkg;
  localparam logic [1:0] SH_PASS  = 2'b00;
  localparam logic [1:0] SH_SHL   = 2'b01;
  localparam logic [1:0] SH_SHR   = 2'b10;
  localparam logic [1:0] SH_RCL   = 2'b11;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_PART  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
endpackage

// File: rtl/alu_res_shifter.sv
// alu_res_shifter: combinational 1-bit post-ALU shift/rotate producing stored data and carry
module alu_res_shifter
  import alu_res_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] f,
  input  logic             co,
  input  logic [1:0]       shift_op,
  output logic [WIDTH-1:0] r,
  output logic             c
);
  // select shifted value and the bit that falls out (RCL rotates the old carry in)
  always_comb begin
    r = shift_op == SH_SHL ? {f[WIDTH-2:0], 1'b0} :
        shift_op == SH_SHR ? {1'b0, f[WIDTH-1:1]} :
        shift_op == SH_RCL ? {f[WIDTH-2:0], co} : f;
    c = shift_op == SH_PASS ? co : shift_op == SH_SHR ? f[0] : f[WIDTH-1];
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU outputs, shifts, queues results in a FIFO and keeps C/Z/NE flags (ALU_RES_PARITY_EN adds flag_p)
module alu_result_stage
  import alu_res_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_co,
  input  logic             alu_fz,
  input  logic [1:0]       shift_op,
  input  logic             flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_co,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_ne
`ifdef ALU_RES_PARITY_EN
  , output logic           flag_p
`endif
);
  localparam int AW = DEPTH > 2 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r;
  logic             c;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] co_mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       state;
  logic             push, pop;

  alu_res_shifter #(.WIDTH(WIDTH)) shifter (
    .f(alu_f), .co(alu_co), .shift_op(shift_op), .r(r), .c(c)
  );

  // occupancy state is decoded from the registered count, so in_ready has no bypass from out_ready
  always_comb begin
    state = count == '0 ? ST_EMPTY : count == CW'(DEPTH) ? ST_FULL : ST_PART;
    in_ready  = state != ST_FULL;
    out_valid = state != ST_EMPTY;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = data_mem[rd_ptr];
    out_co    = co_mem[rd_ptr];
  end

  // FIFO storage, pointers wrapping modulo DEPTH, and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      co_mem <= '0;
      for (int i = 0; i < DEPTH; i++) data_mem[i] <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= r;
        co_mem[wr_ptr]   <= c;
        wr_ptr           <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // status flags follow the accepted entry, regardless of when it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      flag_ne <= 1'b0;
    end else if (push && flag_we) begin
      flag_c  <= c;
      flag_z  <= r == '0;
      flag_ne <= alu_fz;
    end
  end

`ifdef ALU_RES_PARITY_EN
  // even-parity flag of the stored result
  always_ff @(posedge clk) begin
    if (rst) flag_p <= 1'b0;
    else if (push && flag_we) flag_p <= ~^r;
  end
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random checks of alu_result_stage against a queue-based model
module tb_alu_result_stage;
  localparam int DEPTH = 2;
  logic       clk = 1'b0, rst = 1'b0;
  logic       in_valid = 1'b0, in_ready, alu_co = 1'b0, alu_fz = 1'b0, flag_we = 1'b0;
  logic [7:0] alu_f = '0, out_data;
  logic [1:0] shift_op = '0;
  logic       out_valid, out_ready = 1'b0, out_co, flag_c, flag_z, flag_ne;
`ifdef ALU_RES_PARITY_EN
  logic       flag_p;
  logic       m_p = 1'b0;
`endif
  logic [8:0] q[$];
  logic       m_c = 1'b0, m_z = 1'b0, m_ne = 1'b0;
  int         total = 0, bad = 0;

  alu_result_stage #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_f(alu_f), .alu_co(alu_co), .alu_fz(alu_fz), .shift_op(shift_op),
    .flag_we(flag_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_co(out_co), .flag_c(flag_c), .flag_z(flag_z),
    .flag_ne(flag_ne)
`ifdef ALU_RES_PARITY_EN
    , .flag_p(flag_p)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(q[0][7:0]));
      chk("out_co", 32'(out_co), 32'(q[0][8]));
    end
    chk("flag_c", 32'(flag_c), 32'(m_c));
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_ne", 32'(flag_ne), 32'(m_ne));
`ifdef ALU_RES_PARITY_EN
    chk("flag_p", 32'(flag_p), 32'(m_p));
`endif
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b1; alu_f = 8'($urandom); out_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    q.delete(); m_c = 0; m_z = 0; m_ne = 0;
`ifdef ALU_RES_PARITY_EN
    m_p = 0;
`endif
    rst = 1'b0; in_valid = 1'b0;
    check_all();
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_co", 32'(out_co), 32'h0);
  endtask

  task automatic step(input logic v, input logic [7:0] f, input logic co, input logic [1:0] sh,
                      input logic we, input logic fz, input logic ordy);
    int  val, cy;
    bit  pu, po;
    in_valid = v; alu_f = f; alu_co = co; shift_op = sh; flag_we = we; alu_fz = fz; out_ready = ordy;
    case (sh)
      2'd0:    begin val = f;                  cy = co;     end
      2'd1:    begin val = (f * 2) % 256;      cy = f / 128; end
      2'd2:    begin val = f / 2;              cy = f % 2;  end
      default: begin val = (f * 2 + co) % 256; cy = f / 128; end
    endcase
    pu = v && q.size() < DEPTH;
    po = ordy && q.size() > 0;
    @(posedge clk);
    #1;
    if (po) void'(q.pop_front());
    if (pu) begin
      q.push_back({1'(cy), 8'(val)});
      if (we) begin
        m_c = 1'(cy); m_z = (val == 0); m_ne = fz;
`ifdef ALU_RES_PARITY_EN
        m_p = ($countones(8'(val)) % 2) == 0;
`endif
      end
    end
    check_all();
  endtask

  initial begin
    do_reset(2);
    step(0, 8'h00, 0, 2'd0, 0, 0, 1);
    step(1, 8'hA5, 1, 2'd0, 1, 1, 1);
    chk("pass_data", 32'(out_data), 32'hA5);
    step(1, 8'h81, 0, 2'd1, 1, 0, 1);
    chk("shl_data", 32'(out_data), 32'h02);
    step(1, 8'h81, 0, 2'd2, 1, 1, 1);
    chk("shr_data", 32'(out_data), 32'h40);
    step(1, 8'h80, 1, 2'd3, 1, 0, 1);
    chk("rcl_data", 32'(out_data), 32'h01);
    step(1, 8'h80, 0, 2'd1, 1, 0, 1);
    chk("shl_zero_flag", 32'(flag_z), 32'h1);
    step(0, 8'h00, 0, 2'd0, 0, 0, 1);
    step(1, 8'h11, 0, 2'd0, 0, 0, 0);
    step(1, 8'h22, 0, 2'd0, 0, 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    step(1, 8'h99, 1, 2'd0, 1, 1, 0);
    step(0, 8'h00, 0, 2'd0, 0, 0, 0);
    chk("hold_data", 32'(out_data), 32'h11);
    step(0, 8'h00, 0, 2'd0, 0, 0, 1);
    chk("second_data", 32'(out_data), 32'h22);
    step(1, 8'h33, 0, 2'd0, 0, 0, 1);
    chk("pushpop_data", 32'(out_data), 32'h33);
    step(1, 8'h44, 0, 2'd0, 0, 0, 0);
    do_reset(1);
    chk("reset_empty", 32'(out_valid), 32'h0);
`ifdef ALU_RES_PARITY_EN
    step(1, 8'h03, 0, 2'd0, 1, 0, 1);
    chk("parity_even", 32'(flag_p), 32'h1);
    step(1, 8'h07, 0, 2'd0, 1, 0, 1);
    chk("parity_odd", 32'(flag_p), 32'h0);
    step(1, 8'h03, 0, 2'd0, 0, 0, 1);
    chk("parity_hold", 32'(flag_p), 32'h0);
`endif
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0));
    do_reset(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
